// File: rtl/udm_mem_slave.sv
// udm_mem_slave: word-wide RAM responder for the udm debug-master bus
// Ports:
//   clk_i         clock, all state on rising edge
//   rst_i         asynchronous active-high reset
//   bus_req_i     request valid, held by master until ack
//   bus_ack_o     request accepted this cycle (combinational)
//   bus_we_i      1 = write, 0 = read
//   bus_addr_bi   byte address, bits [1:0] ignored
//   bus_wdata_bi  write data
//   bus_resp_o    one-cycle read-response strobe
//   bus_rdata_bo  read data, holds last response when bus_resp_o=0
module udm_mem_slave #(
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int          ADDR_WIDTH    = 10,
  parameter int          ACK_DELAY     = 0,
  parameter int          READ_LATENCY  = 1,
  parameter logic [31:0] RDATA_DEFAULT = 32'hDEAD_BEEF
)(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        bus_req_i,
  output logic        bus_ack_o,
  input  logic        bus_we_i,
  input  logic [31:0] bus_addr_bi,
  input  logic [31:0] bus_wdata_bi,
  output logic        bus_resp_o,
  output logic [31:0] bus_rdata_bo
);
  localparam logic [7:0] STALL_INIT = 8'(ACK_DELAY);
  logic [7:0] stall_q, stall_d;
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [31:0] dat_q [READ_LATENCY];
  logic [31:0] mem [2**ADDR_WIDTH];
  logic [31:0] off;
  logic [ADDR_WIDTH-1:0] idx;
  logic hit, xfer, unused_off;
  // Subtraction wraps, so addresses below BASE_ADDR land far above the window and miss
  assign off = bus_addr_bi - BASE_ADDR;
  assign hit = ~|off[31:ADDR_WIDTH+2];
  assign idx = off[ADDR_WIDTH+1:2];
  assign unused_off = ^off[1:0];
  // A request pending during reset is never acknowledged
  assign bus_ack_o = bus_req_i & ~|stall_q & ~rst_i;
  assign xfer = bus_ack_o;
  always_comb begin
    stall_d = xfer ? STALL_INIT : (|stall_q ? stall_q - 8'd1 : stall_q);
    vld_d = vld_q << 1;
    vld_d[0] = xfer & ~bus_we_i;
  end
  // Data stages only advance with a valid token, so the last stage keeps the last response
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_q <= STALL_INIT;
      vld_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= '0;
    end else begin
      stall_q <= stall_d;
      vld_q <= vld_d;
      if (vld_d[0]) dat_q[0] <= hit ? mem[idx] : RDATA_DEFAULT;
      for (int i = 1; i < READ_LATENCY; i++) if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
    end
  end
  always_ff @(posedge clk_i) if (xfer & bus_we_i & hit) mem[idx] <= bus_wdata_bi;
  assign bus_resp_o = vld_q[READ_LATENCY-1];
  assign bus_rdata_bo = dat_q[READ_LATENCY-1];
endmodule

// File: tb/tb_udm_mem_slave.sv
// tb_udm_mem_slave: scoreboard bench for udm_mem_slave over three parameter sets
module tb_udm_mem_slave;
  typedef struct {logic [31:0] d; int c;} exp_t;
  logic clk = 0;
  logic rst [3];
  logic req [3];
  logic we [3];
  logic ack [3];
  logic resp [3];
  logic [31:0] addr [3];
  logic [31:0] wd [3];
  logic [31:0] rdata [3];
  exp_t q [3][$];
  int rl [3] = '{1, 3, 4};
  int cyc = 0;
  int ncmp = 0;
  int nbad = 0;
  int w;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  udm_mem_slave #(.BASE_ADDR(32'h0), .ADDR_WIDTH(4), .ACK_DELAY(0), .READ_LATENCY(1)) d0 (
    .clk_i(clk), .rst_i(rst[0]), .bus_req_i(req[0]), .bus_ack_o(ack[0]), .bus_we_i(we[0]),
    .bus_addr_bi(addr[0]), .bus_wdata_bi(wd[0]), .bus_resp_o(resp[0]), .bus_rdata_bo(rdata[0]));
  udm_mem_slave #(.BASE_ADDR(32'h8000_0000), .ADDR_WIDTH(6), .ACK_DELAY(3), .READ_LATENCY(3)) d1 (
    .clk_i(clk), .rst_i(rst[1]), .bus_req_i(req[1]), .bus_ack_o(ack[1]), .bus_we_i(we[1]),
    .bus_addr_bi(addr[1]), .bus_wdata_bi(wd[1]), .bus_resp_o(resp[1]), .bus_rdata_bo(rdata[1]));
  udm_mem_slave #(.BASE_ADDR(32'h0), .ADDR_WIDTH(10), .ACK_DELAY(0), .READ_LATENCY(4)) d2 (
    .clk_i(clk), .rst_i(rst[2]), .bus_req_i(req[2]), .bus_ack_o(ack[2]), .bus_we_i(we[2]),
    .bus_addr_bi(addr[2]), .bus_wdata_bi(wd[2]), .bus_resp_o(resp[2]), .bus_rdata_bo(rdata[2]));
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  // Issue one request and hold it until acked; reads optionally queue their expected response
  task automatic xfer(input int k, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic push, output int waits);
    @(negedge clk);
    req[k] = 1; we[k] = wr; addr[k] = a; wd[k] = d;
    #1;
    waits = 0;
    while (!ack[k] && waits < 20) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (!ack[k]) begin
      ncmp++; nbad++;
      $display("FAIL ack_timeout dut%0d addr %h: no ack after %0d cycles", k, a, waits);
    end else if (!wr && push) q[k].push_back('{d, cyc + rl[k]});
  endtask
  task automatic idle(input int k);
    @(negedge clk);
    req[k] = 0;
  endtask
  always @(negedge clk)
    for (int k = 0; k < 3; k++)
      if (resp[k]) begin
        if (q[k].size() == 0) begin
          ncmp++; nbad++;
          $display("FAIL unexpected_resp dut%0d: got resp data %h, none expected", k, rdata[k]);
        end else begin
          exp_t e;
          e = q[k].pop_front();
          chk($sformatf("resp_data_dut%0d", k), rdata[k], e.d);
          chk($sformatf("resp_cycle_dut%0d", k), cyc, e.c);
        end
      end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1; req[k] = 0; we[k] = 0; addr[k] = 0; wd[k] = 0;
    end
    req[0] = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack_blocked", 32'(ack[0]), 0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_resp_dut%0d", k), 32'(resp[k]), 0);
      chk($sformatf("rst_rdata_dut%0d", k), rdata[k], 0);
    end
    @(posedge clk);
    #2;
    for (int k = 0; k < 3; k++) rst[k] = 0;
    req[0] = 0;
    xfer(1, 1, 32'h8000_0040, 32'h77, 0, w);
    chk("ack_first_wait", w, 3);
    for (int i = 0; i < 3; i++) begin
      xfer(1, 1, 32'h8000_0044 + 4 * i, 32'h100 + i, 0, w);
      chk("ack_gap_wait", w, 3);
    end
    xfer(1, 0, 32'h8000_0040, 32'h77, 1, w);
    xfer(1, 0, 32'h8000_0044, 32'h100, 0, w);
    @(negedge clk);
    req[1] = 0;
    rst[1] = 1;
    #1;
    chk("midrst_resp", 32'(resp[1]), 0);
    chk("midrst_rdata", rdata[1], 0);
    @(posedge clk);
    #2;
    rst[1] = 0;
    xfer(1, 0, 32'h8000_0048, 32'h101, 1, w);
    chk("midrst_ack_resume", w, 3);
    idle(1);
    xfer(0, 1, 32'h10, 32'h1234_5678, 0, w);
    chk("ad0_write_wait", w, 0);
    xfer(0, 0, 32'h10, 32'h1234_5678, 1, w);
    chk("ad0_read_wait", w, 0);
    xfer(0, 1, 32'h0, 32'h11, 0, w);
    xfer(0, 1, 32'h3C, 32'hFF, 0, w);
    xfer(0, 0, 32'h40, 32'hDEAD_BEEF, 1, w);
    xfer(0, 0, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 1, w);
    xfer(0, 1, 32'h40, 32'h5555, 0, w);
    xfer(0, 1, 32'hFFFF_FFFC, 32'h6666, 0, w);
    xfer(0, 0, 32'h0, 32'h11, 1, w);
    xfer(0, 0, 32'h3C, 32'hFF, 1, w);
    xfer(0, 1, 32'h20, 32'hAAAA_AAAA, 0, w);
    xfer(0, 0, 32'h20, 32'hAAAA_AAAA, 1, w);
    idle(0);
    repeat (3) @(negedge clk);
    chk("hold_resp", 32'(resp[0]), 0);
    chk("hold_rdata", rdata[0], 32'hAAAA_AAAA);
    for (int i = 0; i < 4; i++) xfer(2, 1, 32'(4 * i), 32'(i + 1), 0, w);
    for (int i = 0; i < 4; i++) xfer(2, 0, 32'(4 * i), 32'(i + 1), 1, w);
    xfer(2, 0, 32'h0, 32'h1, 1, w);
    xfer(2, 1, 32'h0, 32'h99, 0, w);
    xfer(2, 0, 32'h0, 32'h99, 1, w);
    idle(2);
    repeat (10) @(negedge clk);
    for (int k = 0; k < 3; k++) chk($sformatf("pending_dut%0d", k), q[k].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
